// File: rtl/cdc_multi_channel_receiver_pkg.sv
// Shared types and helpers for the multi-channel req/ack receive bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cdc_multi_channel_receiver_pkg;

    // Per-channel handshake state; encodings are fixed so debug dumps read consistently.
    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_CAPTURE = 2'd1,
        RX_HOLD    = 2'd2
    } rx_state_e;

    // Watchdog counter width; a disabled watchdog keeps a minimal 1-bit counter held at zero.
    function automatic int unsigned stale_cnt_width(input int unsigned stale_cycles);
        return (stale_cycles == 0) ? 1 : $clog2(stale_cycles + 1);
    endfunction

endpackage

// File: rtl/cdc_rx_channel.sv
// One receive channel: req synchroniser, 4-phase capture FSM, change detect, staleness watchdog.
// Latency: src_req rise to out_data/out_valid/dst_ack update = SYNC_STAGES+1 clk.
// Backpressure: none on the clk side; the source is throttled by holding dst_ack until req drops.
module cdc_rx_channel
    import cdc_multi_channel_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STALE_CYCLES = 1024,
    parameter bit          CHANGE_ONLY  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_req,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dst_ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_changed,
    output logic                  stale
);

    localparam int unsigned CW = stale_cnt_width(STALE_CYCLES);
    localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("cdc_rx_channel: SYNC_STAGES must be >= 2");
        end
    endgenerate

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   req_s;

    rx_state_e              state_q, state_d;
    logic                   ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   changed_q, changed_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   capture;
    logic                   diff;

    // Shift the asynchronous req level through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], src_req};
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Synchroniser flops: only req crosses here, data is never sampled until capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Handshake FSM: the capture edge loads data, raises ack and emits the pulses together.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        capture   = 1'b0;
        diff      = (src_data != data_q);
        case (state_q)
            RX_IDLE: begin
                ack_d = 1'b0;
                if (req_s) begin
                    capture   = 1'b1;
                    state_d   = RX_CAPTURE;
                    ack_d     = 1'b1;
                    data_d    = src_data;
                    changed_d = diff;
                    valid_d   = CHANGE_ONLY ? diff : 1'b1;
                end
            end
            RX_CAPTURE: begin
                ack_d   = 1'b1;
                state_d = RX_HOLD;
            end
            RX_HOLD: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = RX_IDLE;
            end
        endcase
    end

    // Staleness counter: saturates rather than wrapping so stale stays asserted once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (capture || (STALE_CYCLES == 0)) begin
            cnt_d = '0;
        end else if (cnt_q != STALE_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // FSM, captured data, pulse and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            ack_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dst_ack     = ack_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_changed = changed_q;
    assign stale       = (STALE_CYCLES != 0) && (cnt_q == STALE_MAX);

endmodule

// File: rtl/cdc_multi_channel_receiver.sv
// Receive side of a 4-phase req/ack bridge for NUM_CHANNELS independent registers into clk.
// Latency: src_req rise to out_data/out_valid/dst_ack update = SYNC_STAGES+1 clk per channel.
// Backpressure: per channel, dst_ack stays high until the source drops req; no cross-channel coupling.
module cdc_multi_channel_receiver
    import cdc_multi_channel_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STALE_CYCLES = 1024,
    parameter bit          CHANGE_ONLY  = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS-1:0]            src_req,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] src_data,
    output logic [NUM_CHANNELS-1:0]            dst_ack,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CHANNELS-1:0]            out_valid,
    output logic [NUM_CHANNELS-1:0]            out_changed,
    output logic [NUM_CHANNELS-1:0]            stale
);

    generate
        if (NUM_CHANNELS < 1) begin : g_bad_channels
            $error("cdc_multi_channel_receiver: NUM_CHANNELS must be >= 1");
        end

        // Channels are fully independent; each gets its own synchroniser, FSM and watchdog.
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            cdc_rx_channel #(
                .DATA_WIDTH   (DATA_WIDTH),
                .SYNC_STAGES  (SYNC_STAGES),
                .STALE_CYCLES (STALE_CYCLES),
                .CHANGE_ONLY  (CHANGE_ONLY)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .src_req     (src_req[i]),
                .src_data    (src_data[i*DATA_WIDTH +: DATA_WIDTH]),
                .dst_ack     (dst_ack[i]),
                .out_data    (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
                .out_valid   (out_valid[i]),
                .out_changed (out_changed[i]),
                .stale       (stale[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cdc_multi_channel_receiver.sv
// Bench for the multi-channel req/ack receiver: directed handshakes plus a randomized async source.
// Two instances share stimulus: one with every-capture pulses and a 16-cycle watchdog,
// one with change-only pulses and the watchdog disabled.
module tb_cdc_multi_channel_receiver;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int N_RND = 25;

    logic            clk;
    logic            src_clk;
    logic            rst;
    logic [NC-1:0]   src_req;
    logic [NC*DW-1:0] src_data;

    logic [NC-1:0]    ack_a, valid_a, chg_a, stale_a;
    logic [NC*DW-1:0] data_a;
    logic [NC-1:0]    ack_b, valid_b, chg_b, stale_b;
    logic [NC*DW-1:0] data_b;

    int checks;
    int failures;

    cdc_multi_channel_receiver #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SYNC_STAGES(2),
        .STALE_CYCLES(16), .CHANGE_ONLY(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data),
        .dst_ack(ack_a), .out_data(data_a), .out_valid(valid_a),
        .out_changed(chg_a), .stale(stale_a)
    );

    cdc_multi_channel_receiver #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .SYNC_STAGES(2),
        .STALE_CYCLES(0), .CHANGE_ONLY(1'b1)
    ) dut_co (
        .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data),
        .dst_ack(ack_b), .out_data(data_b), .out_valid(valid_b),
        .out_changed(chg_b), .stale(stale_b)
    );

    // clk posedges at odd ns, source posedges at even ns: the two never coincide.
    initial begin
        clk = 1'b0;
        forever #3 clk = ~clk;
    end

    initial begin
        src_clk = 1'b0;
        #1;
        forever #7 src_clk = ~src_clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 4-phase handshake on one channel; reports which pulses were seen along the way.
    task automatic send(input int ch, input logic [7:0] d,
                        output logic sv_a, output logic sv_b, output logic sc_a);
        sv_a = 1'b0;
        sv_b = 1'b0;
        sc_a = 1'b0;
        src_data[ch*DW +: DW] = d;
        src_req[ch] = 1'b1;
        for (int i = 0; i < 12 && !ack_a[ch]; i++) begin
            tick();
            sv_a |= valid_a[ch];
            sv_b |= valid_b[ch];
            sc_a |= chg_a[ch];
        end
        chk("send_ack_rise", 32'(ack_a[ch]), 32'd1);
        src_req[ch] = 1'b0;
        for (int i = 0; i < 12 && ack_a[ch]; i++) begin
            tick();
            sv_a |= valid_a[ch];
            sv_b |= valid_b[ch];
            sc_a |= chg_a[ch];
        end
        chk("send_ack_fall", 32'(ack_a[ch]), 32'd0);
    endtask

    // Randomized-phase state
    logic [7:0]  sent_q [NC][$];
    logic [7:0]  last_v [NC];
    logic [NC-1:0] as1, as2;
    int          ph [NC];
    int          cnt [NC];
    int          nsent [NC];
    bit          src_done;
    logic [7:0]  rnd;
    logic [7:0]  exp_w;

    initial begin
        logic sa, sb, sc;
        checks   = 0;
        failures = 0;
        src_done = 1'b0;
        rst      = 1'b1;
        src_req  = '0;
        src_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ack", 32'(ack_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data", data_a, 32'd0);
        chk("rst_changed", 32'(chg_a), 32'd0);
        chk("rst_stale", 32'(stale_a), 32'd0);

        // 1: single capture on ch0, exact 3-cycle latency
        src_data[7:0] = 8'hA5;
        src_req[0] = 1'b1;
        tick();
        chk("t1_noval_c1", 32'(valid_a[0]), 32'd0);
        tick();
        chk("t1_noval_c2", 32'(valid_a[0]), 32'd0);
        chk("t1_noack_c2", 32'(ack_a[0]), 32'd0);
        tick();
        chk("t1_valid_c3", 32'(valid_a[0]), 32'd1);
        chk("t1_ack_c3", 32'(ack_a[0]), 32'd1);
        chk("t1_data", 32'(data_a[7:0]), 32'hA5);
        chk("t1_changed", 32'(chg_a[0]), 32'd1);
        chk("t1_co_valid", 32'(valid_b[0]), 32'd1);
        tick();
        chk("t1_pulse_1cyc", 32'(valid_a[0]), 32'd0);
        src_req[0] = 1'b0;
        tick();
        tick();
        chk("t1_ack_held", 32'(ack_a[0]), 32'd1);
        tick();
        chk("t1_ack_drop", 32'(ack_a[0]), 32'd0);
        chk("t1_data_held", 32'(data_a[7:0]), 32'hA5);

        // 2: change-only behaviour on ch1 with A5, A5, 3C
        send(1, 8'hA5, sa, sb, sc);
        chk("t2_w0_va", 32'(sa), 32'd1);
        chk("t2_w0_vb", 32'(sb), 32'd1);
        chk("t2_w0_chg", 32'(sc), 32'd1);
        send(1, 8'hA5, sa, sb, sc);
        chk("t2_w1_va", 32'(sa), 32'd1);
        chk("t2_w1_vb", 32'(sb), 32'd0);
        chk("t2_w1_chg", 32'(sc), 32'd0);
        send(1, 8'h3C, sa, sb, sc);
        chk("t2_w2_va", 32'(sa), 32'd1);
        chk("t2_w2_vb", 32'(sb), 32'd1);
        chk("t2_w2_chg", 32'(sc), 32'd1);
        chk("t2_data_a", 32'(data_a[15:8]), 32'h3C);
        chk("t2_data_b", 32'(data_b[15:8]), 32'h3C);

        // 3: all four channels simultaneously
        src_data = 32'h44332211;
        src_req  = 4'hF;
        tick();
        tick();
        tick();
        chk("t3_valid_all", 32'(valid_a), 32'hF);
        chk("t3_ack_all", 32'(ack_a), 32'hF);
        chk("t3_data", data_a, 32'h44332211);
        chk("t3_co_valid", 32'(valid_b), 32'hF);
        src_req = '0;
        for (int i = 0; i < 12 && ack_a != '0; i++) tick();
        chk("t3_ack_clear", 32'(ack_a), 32'd0);

        // 5: reset while ch2 is holding with req high, then recapture
        src_data[23:16] = 8'h5A;
        src_req[2] = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_first_capture", 32'(valid_a[2]), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ack_reset", 32'(ack_a[2]), 32'd0);
        chk("t5_data_reset", data_a, 32'd0);
        tick();
        tick();
        chk("t5_no_early", 32'(valid_a[2]), 32'd0);
        tick();
        chk("t5_recapture", 32'(valid_a[2]), 32'd1);
        chk("t5_reack", 32'(ack_a[2]), 32'd1);
        chk("t5_redata", 32'(data_a[23:16]), 32'h5A);
        src_req[2] = 1'b0;
        for (int i = 0; i < 12 && ack_a[2]; i++) tick();
        chk("t5_ack_clear", 32'(ack_a[2]), 32'd0);

        // 4: watchdog, 16 idle cycles then a capture on ch3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("t4_not_stale_15", 32'(stale_a), 32'd0);
        tick();
        chk("t4_stale_16", 32'(stale_a), 32'hF);
        chk("t4_co_disabled", 32'(stale_b), 32'd0);
        src_data[31:24] = 8'h77;
        src_req[3] = 1'b1;
        tick();
        tick();
        chk("t4_still_stale", 32'(stale_a), 32'hF);
        tick();
        chk("t4_cleared", 32'(stale_a), 32'h7);
        src_req[3] = 1'b0;
        repeat (20) tick();
        chk("t4_saturated", 32'(stale_a[2:0]), 32'h7);
        chk("t4_ch3_rearm", 32'(stale_a[3]), 32'd1);

        // 6: randomized asynchronous source, 7:3 clock ratio, against an in-order word scoreboard
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        src_req = '0;
        for (int c = 0; c < NC; c++) begin
            last_v[c] = 8'h00;
            ph[c]     = 0;
            cnt[c]    = 1;
            nsent[c]  = 0;
        end
        as1 = '0;
        as2 = '0;
        fork
            begin : source
                for (int it = 0; it < 6000 && !src_done; it++) begin
                    @(posedge src_clk);
                    as2 = as1;
                    as1 = ack_a;
                    for (int c = 0; c < NC; c++) begin
                        case (ph[c])
                            0: begin
                                if (cnt[c] > 0) begin
                                    rnd = 8'($urandom_range(0, 7));
                                    src_data[c*DW +: DW] = rnd * 8'd37;
                                    cnt[c]--;
                                end else begin
                                    src_req[c] = 1'b1;
                                    sent_q[c].push_back(src_data[c*DW +: DW]);
                                    ph[c] = 1;
                                end
                            end
                            1: begin
                                if (as2[c]) begin
                                    src_req[c] = 1'b0;
                                    ph[c] = 2;
                                end
                            end
                            2: begin
                                if (!as2[c]) begin
                                    nsent[c]++;
                                    if (nsent[c] < N_RND) begin
                                        cnt[c] = $urandom_range(1, 3);
                                        ph[c]  = 0;
                                    end else begin
                                        ph[c] = 3;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                    src_done = (ph[0] == 3) && (ph[1] == 3) && (ph[2] == 3) && (ph[3] == 3);
                end
                src_done = 1'b1;
            end
            begin : monitor
                int budget;
                budget = 0;
                while (!src_done && budget < 30000) begin
                    tick();
                    budget++;
                    for (int c = 0; c < NC; c++) begin
                        if (valid_a[c]) begin
                            if (sent_q[c].size() == 0) begin
                                chk("rnd_unexpected_capture", 32'd1, 32'd0);
                            end else begin
                                exp_w = sent_q[c].pop_front();
                                chk("rnd_data_a", 32'(data_a[c*DW +: DW]), 32'(exp_w));
                                chk("rnd_data_b", 32'(data_b[c*DW +: DW]), 32'(exp_w));
                                chk("rnd_changed", 32'(chg_a[c]), 32'(exp_w != last_v[c]));
                                chk("rnd_co_valid", 32'(valid_b[c]), 32'(exp_w != last_v[c]));
                                chk("rnd_co_changed", 32'(chg_b[c]), 32'(exp_w != last_v[c]));
                                last_v[c] = exp_w;
                            end
                        end else if (valid_b[c]) begin
                            chk("rnd_co_spurious", 32'(valid_b[c]), 32'd0);
                        end
                    end
                end
                chk("rnd_finished", 32'(budget < 30000), 32'd1);
            end
        join
        for (int c = 0; c < NC; c++) begin
            chk("rnd_all_captured", 32'(sent_q[c].size()), 32'd0);
            chk("rnd_count", 32'(nsent[c]), 32'(N_RND));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
